// File: rtl/core_param_loader.sv
// core_param_loader: streams one core's configuration from a 32-bit
// valid/ready word stream into the core's neuron parameter port (368-bit
// records, addresses 0..255) and neuron instruction port (2-bit
// instructions, addresses 0..255), and holds off the core's tick while a
// load is running.
// Optional feature macro: CORE_LOADER_CHECKSUM_EN adds a trailer word that is
// compared against the running XOR of all accepted data words.
module core_param_loader #(
    parameter int NUM_NEURONS = 256,
    parameter int PARAM_WIDTH = 368,
    parameter int BUS_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   param_wen,
    output logic [PARAM_WIDTH-1:0] param_data_in,
    output logic [7:0]             param_address,
    output logic                   neuron_inst_wen,
    output logic [7:0]             neuron_inst_address,
    output logic [1:0]             neuron_inst_data_in,
    input  logic                   tick_in,
    output logic                   tick_out,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // Beats per record; the last beat carries only the top TAIL_W bits.
    localparam int BEATS      = (PARAM_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int BUF_W      = (BEATS - 1) * BUS_WIDTH;
    localparam int TAIL_W     = PARAM_WIDTH - BUF_W;
    localparam int SLOTS      = BUS_WIDTH / 2;
    localparam int INST_WORDS = NUM_NEURONS / SLOTS;

    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
    localparam logic [7:0] LAST_ADDR = 8'(NUM_NEURONS - 1);
    localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);
    localparam logic [3:0] LAST_WORD = 4'(INST_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        P_COL,
        P_WR,
        I_COL,
        I_WR,
`ifdef CORE_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

    state_t                 state, state_n;
    logic [7:0]             addr, addr_n;
    logic [3:0]             beat, beat_n;
    logic [3:0]             wcnt, wcnt_n;
    logic [3:0]             slot, slot_n, slot_inc;
    logic [BUF_W-1:0]       rec_buf, rec_buf_n;
    logic [BUS_WIDTH-1:0]   word_q, word_n;
    logic                   param_wen_n, inst_wen_n, done_n, busy_n;
    logic [PARAM_WIDTH-1:0] param_data_n;
    logic [7:0]             param_addr_n, inst_addr_n;
    logic [1:0]             inst_data_n;
`ifdef CORE_LOADER_CHECKSUM_EN
    logic [BUS_WIDTH-1:0]   csum, csum_n;
    logic                   error_n;
`endif

    // Only the collect states (and the trailer check) take stream words;
    // ticks pass straight through whenever no load is running.
`ifdef CORE_LOADER_CHECKSUM_EN
    assign s_ready  = (state == P_COL) || (state == I_COL) || (state == CHK);
`else
    assign s_ready  = (state == P_COL) || (state == I_COL);
    assign error    = 1'b0;
`endif
    assign tick_out = tick_in & ~busy;

    // Next state plus the values every registered output takes in that state,
    // so strobes line up with the P_WR / I_WR / DONE cycles themselves.
    always_comb begin
        state_n      = state;
        addr_n       = addr;
        beat_n       = beat;
        wcnt_n       = wcnt;
        slot_n       = slot;
        slot_inc     = slot + 4'd1;
        rec_buf_n    = rec_buf;
        word_n       = word_q;
        param_wen_n  = 1'b0;
        param_data_n = param_data_in;
        param_addr_n = param_address;
        inst_wen_n   = 1'b0;
        inst_addr_n  = neuron_inst_address;
        inst_data_n  = neuron_inst_data_in;
        done_n       = 1'b0;
`ifdef CORE_LOADER_CHECKSUM_EN
        csum_n       = csum;
        error_n      = error;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = P_COL;
                    addr_n  = 8'd0;
                    beat_n  = 4'd0;
                    wcnt_n  = 4'd0;
`ifdef CORE_LOADER_CHECKSUM_EN
                    csum_n  = '0;
                    error_n = 1'b0;
`endif
                end
            end
            P_COL: begin
                if (s_valid) begin
`ifdef CORE_LOADER_CHECKSUM_EN
                    csum_n = csum ^ s_data;
`endif
                    if (beat == LAST_BEAT) begin
                        state_n      = P_WR;
                        beat_n       = 4'd0;
                        param_wen_n  = 1'b1;
                        param_addr_n = addr;
                        param_data_n = {s_data[TAIL_W-1:0], rec_buf};
                    end else begin
                        rec_buf_n[int'(beat)*BUS_WIDTH +: BUS_WIDTH] = s_data;
                        beat_n = beat + 4'd1;
                    end
                end
            end
            P_WR: begin
                if (addr == LAST_ADDR) begin
                    state_n = I_COL;
                    addr_n  = 8'd0;
                end else begin
                    state_n = P_COL;
                    addr_n  = addr + 8'd1;
                end
            end
            I_COL: begin
                if (s_valid) begin
`ifdef CORE_LOADER_CHECKSUM_EN
                    csum_n = csum ^ s_data;
`endif
                    state_n     = I_WR;
                    word_n      = s_data;
                    slot_n      = 4'd0;
                    inst_wen_n  = 1'b1;
                    inst_addr_n = addr;
                    inst_data_n = s_data[1:0];
                end
            end
            I_WR: begin
                addr_n = addr + 8'd1;
                slot_n = slot_inc;
                if (slot != LAST_SLOT) begin
                    inst_wen_n  = 1'b1;
                    inst_addr_n = addr + 8'd1;
                    inst_data_n = word_q[2*int'(slot_inc) +: 2];
                end else if (wcnt == LAST_WORD) begin
`ifdef CORE_LOADER_CHECKSUM_EN
                    state_n = CHK;
`else
                    state_n = DONE;
                    done_n  = 1'b1;
`endif
                end else begin
                    state_n = I_COL;
                    wcnt_n  = wcnt + 4'd1;
                end
            end
`ifdef CORE_LOADER_CHECKSUM_EN
            CHK: begin
                if (s_valid) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    error_n = (s_data != csum);
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset drops everything to zero at once,
    // abandoning any load in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            addr                <= 8'd0;
            beat                <= 4'd0;
            wcnt                <= 4'd0;
            slot                <= 4'd0;
            rec_buf             <= '0;
            word_q              <= '0;
            param_wen           <= 1'b0;
            param_data_in       <= '0;
            param_address       <= 8'd0;
            neuron_inst_wen     <= 1'b0;
            neuron_inst_address <= 8'd0;
            neuron_inst_data_in <= 2'd0;
            busy                <= 1'b0;
            done                <= 1'b0;
`ifdef CORE_LOADER_CHECKSUM_EN
            csum                <= '0;
            error               <= 1'b0;
`endif
        end else begin
            state               <= state_n;
            addr                <= addr_n;
            beat                <= beat_n;
            wcnt                <= wcnt_n;
            slot                <= slot_n;
            rec_buf             <= rec_buf_n;
            word_q              <= word_n;
            param_wen           <= param_wen_n;
            param_data_in       <= param_data_n;
            param_address       <= param_addr_n;
            neuron_inst_wen     <= inst_wen_n;
            neuron_inst_address <= inst_addr_n;
            neuron_inst_data_in <= inst_data_n;
            busy                <= busy_n;
            done                <= done_n;
`ifdef CORE_LOADER_CHECKSUM_EN
            csum                <= csum_n;
            error               <= error_n;
`endif
        end
    end

endmodule

// File: tb/tb_core_param_loader.sv
// tb_core_param_loader: drives full configuration loads into core_param_loader
// and compares every parameter and instruction write against records derived
// directly from the word stream.
module tb_core_param_loader;

`ifdef CORE_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int N_PARAM_WORDS = 3072;
    localparam int N_INST_WORDS  = 16;
    localparam int N_STREAM      = N_PARAM_WORDS + N_INST_WORDS + int'(CHK_EN);
    localparam int BASE_LATENCY  = 256*13 + 16*17 + 1;

    logic         clk = 1'b0;
    logic         reset_n, start, s_valid, s_ready, tick_in, tick_out;
    logic [31:0]  s_data;
    logic         param_wen, neuron_inst_wen, busy, done, error;
    logic [367:0] param_data_in;
    logic [7:0]   param_address, neuron_inst_address;
    logic [1:0]   neuron_inst_data_in;

    core_param_loader dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .param_wen           (param_wen),
        .param_data_in       (param_data_in),
        .param_address       (param_address),
        .neuron_inst_wen     (neuron_inst_wen),
        .neuron_inst_address (neuron_inst_address),
        .neuron_inst_data_in (neuron_inst_data_in),
        .tick_in             (tick_in),
        .tick_out            (tick_out),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    logic [31:0] stream [0:N_PARAM_WORDS+N_INST_WORDS];

    typedef struct {
        int pct;
        int tick_period;
        int data_mode;
        bit bad_trailer;
        int restart_addr;
        int exp_latency;
        bit exp_error;
        bit chk_rec0;
    } vec_t;

    vec_t vecs [5];

    task automatic check_output(input string name, input logic [367:0] act, input logic [367:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Record n is the twelve stream words 12n..12n+11 laid end to end, low word first.
    function automatic logic [367:0] exp_record(input int n);
        logic [383:0] r;
        for (int b = 0; b < 12; b++) r[32*b +: 32] = stream[12*n + b];
        return r[367:0];
    endfunction

    // Instruction for neuron a is 2-bit slot (a mod 16) of instruction word a/16.
    function automatic logic [1:0] exp_inst(input int a);
        logic [31:0] w;
        w = stream[N_PARAM_WORDS + a/16];
        return w[2*(a%16) +: 2];
    endfunction

    task automatic fill_stream(input int mode, input bit bad);
        logic [31:0] x;
        for (int i = 0; i < N_PARAM_WORDS; i++)
            stream[i] = (mode == 0) ? 32'(i) : $urandom;
        for (int j = 0; j < N_INST_WORDS; j++)
            stream[N_PARAM_WORDS + j] = (mode == 0) ? 32'hE4E4_E4E4 : $urandom;
        x = '0;
        for (int i = 0; i < N_PARAM_WORDS + N_INST_WORDS; i++) x ^= stream[i];
        stream[N_PARAM_WORDS + N_INST_WORDS] = bad ? (x ^ 32'd1) : x;
    endtask

    // One load: start pulse, then a cycle loop that samples outputs at the
    // falling edge and drives the next inputs.
    task automatic apply_stimulus(input int pct, input int tick_period, input int restart_addr,
                                  input int abort_addr, output int latency,
                                  output logic [367:0] first_rec, output bit aborted);
        int pw_cnt = 0, pw_bad = 0, iw_cnt = 0, iw_bad = 0, done_cnt = 0;
        int rdy_bad = 0, tick_bad = 0, busy_bad = 0, idx = 0, cyc = 0;
        bit done_seen = 0;
        latency   = 0;
        first_rec = '0;
        aborted   = 0;
        @(negedge clk);
        start   = 1'b1;
        tick_in = 1'b1;
        s_valid = 1'b0;
        #1 check_output("tick_with_start", tick_out, 1'b1);
        while (!done_seen && !aborted && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (param_wen) begin
                if (pw_cnt == 0) first_rec = param_data_in;
                if (pw_cnt >= 256) pw_bad++;
                else if (param_address != 8'(pw_cnt) || param_data_in != exp_record(pw_cnt)) pw_bad++;
                if (abort_addr >= 0 && int'(param_address) == abort_addr) aborted = 1;
                if (restart_addr >= 0 && int'(param_address) == restart_addr) start = 1'b1;
                pw_cnt++;
            end
            if (neuron_inst_wen) begin
                if (iw_cnt >= 256) iw_bad++;
                else if (neuron_inst_address != 8'(iw_cnt) || neuron_inst_data_in != exp_inst(iw_cnt)) iw_bad++;
                iw_cnt++;
            end
            if ((param_wen || neuron_inst_wen) && s_ready) rdy_bad++;
            if (busy && tick_out) tick_bad++;
            if (!busy && tick_out !== tick_in) tick_bad++;
            if (!busy) busy_bad++;
            if (done) begin
                done_cnt++;
                done_seen = 1;
                latency   = cyc;
            end
            s_valid = (idx < N_STREAM) && ($urandom_range(99) < pct);
            s_data  = s_valid ? stream[idx] : $urandom;
            if (s_valid && s_ready) idx++;
            tick_in = (tick_period > 0) && (cyc % tick_period == 0);
        end
        s_valid = 1'b0;
        if (aborted) begin
            tick_in = 1'b0;
            start   = 1'b0;
            return;
        end
        check_output("load_timeout", done_seen, 1'b1);
        check_output("param_count", pw_cnt, 256);
        check_output("param_bad_writes", pw_bad, 0);
        check_output("inst_count", iw_cnt, 256);
        check_output("inst_bad_writes", iw_bad, 0);
        check_output("ready_during_write", rdy_bad, 0);
        check_output("tick_gating", tick_bad, 0);
        check_output("busy_during_load", busy_bad, 0);
        check_output("words_consumed", idx, N_STREAM);
        tick_in = 1'b1;
        @(negedge clk);
        check_output("tick_after_done", tick_out, 1'b1);
        check_output("idle_after_done", busy, 1'b0);
        tick_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_output("done_count", done_cnt, 1);
    endtask

    initial begin
        int           lat;
        logic [367:0] rec0, exp_rec0;
        bit           ab;

        for (int k = 0; k < 11; k++) exp_rec0[32*k +: 32] = 32'(k);
        exp_rec0[367:352] = 16'h000B;

        vecs[0] = '{100,   0, 0, 1'b0,  -1, BASE_LATENCY + int'(CHK_EN), 1'b0,   1'b1};
        vecs[1] = '{ 50,   0, 0, 1'b0,  -1, 0,                           1'b0,   1'b1};
        vecs[2] = '{100, 100, 1, 1'b0,  -1, BASE_LATENCY + int'(CHK_EN), 1'b0,   1'b0};
        vecs[3] = '{ 70,   0, 1, 1'b1,  -1, 0,                           CHK_EN, 1'b0};
        vecs[4] = '{100,   0, 1, 1'b0, 100, BASE_LATENCY + int'(CHK_EN), 1'b0,   1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_param_wen", param_wen, 1'b0);
        check_output("rst_param_data", param_data_in, '0);
        check_output("rst_param_addr", param_address, 8'd0);
        check_output("rst_inst_wen", neuron_inst_wen, 1'b0);
        check_output("rst_inst_addr", neuron_inst_address, 8'd0);
        check_output("rst_inst_data", neuron_inst_data_in, 2'd0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_error", error, 1'b0);
        check_output("rst_ready", s_ready, 1'b0);
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            $display("[TB] load %0d: valid %0d%%, tick period %0d", v, vecs[v].pct, vecs[v].tick_period);
            fill_stream(vecs[v].data_mode, vecs[v].bad_trailer);
            apply_stimulus(vecs[v].pct, vecs[v].tick_period, vecs[v].restart_addr, -1, lat, rec0, ab);
            if (vecs[v].exp_latency != 0) check_output("latency", lat, vecs[v].exp_latency);
            if (vecs[v].chk_rec0) check_output("record0", rec0, exp_rec0);
            check_output("error_flag", error, vecs[v].exp_error);
        end

        $display("[TB] reset during parameter section");
        fill_stream(1, 1'b0);
        apply_stimulus(100, 0, -1, 37, lat, rec0, ab);
        check_output("abort_reached", ab, 1'b1);
        check_output("abort_addr_seen", param_address, 8'd37);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 1'b0);
        check_output("abort_ready", s_ready, 1'b0);
        check_output("abort_param_addr", param_address, 8'd0);
        check_output("abort_param_data", param_data_in, '0);
        check_output("abort_outputs", {param_wen, neuron_inst_wen, neuron_inst_address,
                                       neuron_inst_data_in, done, error}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(100, 0, -1, -1, lat, rec0, ab);
        check_output("reload_latency", lat, BASE_LATENCY + int'(CHK_EN));

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
